// File: rtl/store_narrow_unit.sv
// Store narrowing unit for the MEM stage of the multi-cycle datapath.
// Narrows a 32-bit register value to a byte, halfword or word store. It places
// the data on the memory byte lanes, builds the byte enables and checks the
// alignment. It then runs a req/ack write to data memory with a timeout and
// reports completion to the control FSM.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           one-cycle store request, sampled only while idle
//   size            00 byte, 01 halfword, 10 word, 11 illegal
//   addr            byte address of the store
//   wdata           register value; low bits used for narrow stores
//   mem_req         write request to data memory
//   mem_addr        word-aligned address
//   mem_wdata       lane-replicated write data
//   mem_be          byte enables, bit i = byte lane i (little-endian)
//   mem_ack         memory accepted the write (meaningful only with mem_req)
//   busy            unit not idle
//   done            one-cycle completion pulse
//   err             one-cycle pulse with done on misalign/illegal size/timeout
module store_narrow_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            size,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_mem_req;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic [3:0]            r_mem_be;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_legal;
  logic [3:0]            w_be;
  logic [31:0]           w_lane_data;
  logic [ADDR_WIDTH-1:0] w_word_addr;

  // Lane placement, byte enables and alignment check for the incoming request.
  always_comb begin
    w_legal     = 1'b0;
    w_be        = 4'b0000;
    w_lane_data = 32'h0;
    case (size)
      2'b00: begin
        w_legal     = 1'b1;
        w_be        = 4'b0001 << addr[1:0];
        w_lane_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_legal     = ~addr[0];
        w_be        = addr[1] ? 4'b1100 : 4'b0011;
        w_lane_data = {2{wdata[15:0]}};
      end
      2'b10: begin
        w_legal     = (addr[1:0] == 2'b00);
        w_be        = 4'b1111;
        w_lane_data = wdata;
      end
      default: begin
        w_legal     = 1'b0;
        w_be        = 4'b0000;
        w_lane_data = 32'h0;
      end
    endcase
  end

  assign w_word_addr = {addr[ADDR_WIDTH-1:2], 2'b00};

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0;
      r_mem_be    <= 4'b0000;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            if (w_legal) begin
              r_state     <= S_REQ;
              r_mem_req   <= 1'b1;
              r_mem_addr  <= w_word_addr;
              r_mem_wdata <= w_lane_data;
              r_mem_be    <= w_be;
            end else begin
              // Illegal request never reaches memory.
              r_state <= S_FIN;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end

        S_REQ: begin
          if (mem_ack || (r_cnt == CNT_LAST)) begin
            // Ack takes priority over a coincident timeout.
            r_state     <= S_FIN;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
            r_mem_be    <= 4'b0000;
            r_done      <= 1'b1;
            r_err       <= ~mem_ack;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_FIN: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end

        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_mem_req   <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= 32'h0;
          r_mem_be    <= 4'b0000;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_err       <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Testbench for store_narrow_unit. Each transaction is turned into a
// cycle-indexed schedule of expected outputs: lane and enable values, the REQ
// length and the completion flags. A single compare process checks the DUT
// against that schedule on every cycle.
module tb_store_narrow_unit;

  localparam int T = 16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        err;

  store_narrow_unit #(.ADDR_WIDTH(32), .TIMEOUT(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        busy;
    logic        done;
    logic        err;
  } rec_t;

  rec_t exp_q [int];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, required %0h", name, cyc, act, expv);
    end
  endtask

  // Reference model: access size in bytes, legality, enables and lane data.
  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit m_legal(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b0;
    return (a % nbytes(sz)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int nb = nbytes(sz);
    int mask = ((1 << nb) - 1) << (a % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_data(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] d;
    int nb = nbytes(sz);
    d = '0;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = wd[8*(i % nb) +: 8];
    return d;
  endfunction

  function automatic rec_t mk(input logic req, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, input logic b, input logic dn, input logic er);
    rec_t r;
    r.req = req; r.addr = a; r.wd = wd; r.be = be; r.busy = b; r.done = dn; r.err = er;
    return r;
  endfunction

  // Compare process: cycles without a scheduled entry must look idle.
  always @(negedge clk) begin
    rec_t e;
    e = mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    if (exp_q.exists(cyc)) begin
      e = exp_q[cyc];
      exp_q.delete(cyc);
    end
    chk("mem_req", 64'(mem_req), 64'(e.req));
    chk("mem_wdata", 64'(mem_wdata), 64'(e.wd));
    chk("mem_be", 64'(mem_be), 64'(e.be));
    chk("busy", 64'(busy), 64'(e.busy));
    chk("done", 64'(done), 64'(e.done));
    chk("err", 64'(err), 64'(e.err));
    if (e.req) chk("mem_addr", 64'(mem_addr), 64'(e.addr));
  end

  // One store: d is the REQ-cycle index at which ack is driven (d >= T means never).
  // The task returns at the first idle negedge after done.
  task automatic run_txn(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                         input int d, input bit poke, input bit pin_en,
                         input logic [31:0] p_addr, input logic [31:0] p_wd,
                         input logic [3:0] p_be, input int p_done, input bit p_err);
    int c, n, off;
    bit legal, acked;
    logic [31:0] wa;
    c = cyc;
    legal = m_legal(sz, a);
    acked = legal && (d < T);
    wa = {a[31:2], 2'b00};
    if (!legal) begin
      n = 0;
      exp_q[c + 1] = mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1);
    end else begin
      n = acked ? d + 1 : T;
      for (int j = 0; j < n; j++)
        exp_q[c + 1 + j] = mk(1'b1, wa, m_data(sz, wd), m_be(sz, a), 1'b1, 1'b0, 1'b0);
      exp_q[c + 1 + n] = mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, !acked);
    end
    start = 1'b1; size = sz; addr = a; wdata = wd;
    mem_ack = 1'($urandom % 2);
    @(negedge clk);
    while (cyc < c + 2 + n) begin
      off = cyc - c;
      if (pin_en && legal && off == 1) begin
        chk("pin_mem_addr", 64'(mem_addr), 64'(p_addr));
        chk("pin_mem_wdata", 64'(mem_wdata), 64'(p_wd));
        chk("pin_mem_be", 64'(mem_be), 64'(p_be));
      end
      if (pin_en && off == p_done) begin
        chk("pin_done", 64'(done), 64'd1);
        chk("pin_err", 64'(err), 64'(p_err));
      end
      start = poke && ($urandom % 3 == 0);
      size = 2'($urandom);
      addr = $urandom;
      wdata = $urandom;
      mem_ack = acked && (off == 1 + d);
      @(negedge clk);
    end
    start = 1'b0;
    mem_ack = 1'b0;
  endtask

  // Idle gap with ack noise, which an idle unit must ignore.
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      start = 1'b0;
      mem_ack = 1'($urandom % 2);
      addr = $urandom;
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of run, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    logic [31:0] wd;
    rst_n = 1'b0; start = 1'b0; size = 2'b00; addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a word request.
    c = cyc;
    wd = $urandom;
    start = 1'b1; size = 2'b10; addr = 32'h100; wdata = wd;
    for (int j = 0; j < T; j++) exp_q[c + 1 + j] = mk(1'b1, 32'h100, wd, 4'hF, 1'b1, 1'b0, 1'b0);
    exp_q[c + 1 + T] = mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_pre_mem_req", 64'(mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_mem_be", 64'(mem_be), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    idle(2);

    // Byte store, zero-wait memory.
    run_txn(2'b00, 32'h1003, 32'h123456AB, 0, 1'b0, 1'b1, 32'h1000, 32'hABABABAB, 4'b1000, 2, 1'b0);
    idle(1);
    // Halfword store, ack after three wait cycles.
    run_txn(2'b01, 32'h2002, 32'hDEADBEEF, 3, 1'b0, 1'b1, 32'h2000, 32'hBEEFBEEF, 4'b1100, 5, 1'b0);
    idle(1);
    // Illegal requests finish at once with err.
    run_txn(2'b10, 32'h3002, 32'h11111111, 0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1, 1'b1);
    run_txn(2'b01, 32'h3001, 32'h22222222, 0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1, 1'b1);
    run_txn(2'b11, 32'h3000, 32'h33333333, 0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1, 1'b1);
    idle(1);
    // Timeout with start pulses while busy.
    run_txn(2'b10, 32'h4000, 32'hCAFEF00D, T, 1'b1, 1'b1, 32'h4000, 32'hCAFEF00D, 4'hF, T + 1, 1'b1);
    // Ack coincident with timeout: ack wins.
    run_txn(2'b10, 32'h4004, 32'h0BADF00D, T - 1, 1'b0, 1'b1, 32'h4004, 32'h0BADF00D, 4'hF, T + 1, 1'b0);
    // Back-to-back: second start on the first idle cycle after done.
    run_txn(2'b00, 32'h5001, 32'h000000C3, 1, 1'b0, 1'b1, 32'h5000, 32'hC3C3C3C3, 4'b0010, 3, 1'b0);
    run_txn(2'b01, 32'h5000, 32'h0000A55A, 0, 1'b0, 1'b1, 32'h5000, 32'hA55AA55A, 4'b0011, 2, 1'b0);

    // Randomized transactions.
    for (int i = 0; i < 200; i++) begin
      run_txn(2'($urandom), $urandom, $urandom, int'($urandom_range(0, T + 2)),
              1'($urandom % 2), 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0);
      idle(int'($urandom_range(0, 3)));
    end

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
- Store-side counterpart of the load-path extenders: narrows a 32-bit register value to byte/halfword/word.
- Places the value on the correct memory byte lanes, generates byte enables and detects misalignment.
- Drives a req/ack handshake to data memory for the multi-cycle datapath's MEM stage.
- Holds the write stable until memory acknowledges, then reports completion or error to the control FSM.

Parameters:
- ADDR_WIDTH, 32, width of byte address and mem_addr
- TIMEOUT, 16, max cycles in REQ without mem_ack before aborting with error (≥1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle store request from control; sampled only in IDLE
- size  input  2  00 byte (sb), 01 halfword (sh), 10 word (sw), 11 illegal
- addr  input  ADDR_WIDTH  byte address of store
- wdata  input  32  register value; low bits used for narrow stores
- mem_req  output  1  write request to data memory
- mem_addr  output  ADDR_WIDTH  word-aligned address {addr[AW-1:2],2'b00}
- mem_wdata  output  32  lane-replicated write data
- mem_be  output  4  byte enables, bit i = byte lane i (little-endian)
- mem_ack  input  1  memory accepted write; valid only while mem_req=1
- busy  output  1  unit not in IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse coincident with done on misalign/illegal size/timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 (mem_addr, mem_wdata, mem_be = 0); timeout counter 0. Takes effect immediately, including mid-REQ; mem_req drops without waiting for ack.
- States: IDLE, REQ, FIN. busy = (state != IDLE).
- IDLE, start=1 and request legal: register outputs and go to REQ; mem_req=1 from the next cycle.
  - Byte: mem_wdata = {4{wdata[7:0]}}, mem_be = 4'b0001 << addr[1:0].
  - Half: mem_wdata = {2{wdata[15:0]}}, mem_be = addr[1] ? 4'b1100 : 4'b0011.
  - Word: mem_wdata = wdata, mem_be = 4'b1111.
- IDLE, start=1 and request illegal: go to FIN with err flag set; mem_req never asserts, mem_be stays 0. Illegal means:
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]≠0.
- IDLE, start=0: hold. mem_ack is ignored in IDLE.
- REQ: mem_req, mem_addr, mem_wdata and mem_be are held stable. The counter increments each cycle.
  - mem_ack=1 sampled: go to FIN with err=0; mem_req low from the next cycle.
  - Counter reaches TIMEOUT without ack: go to FIN with err=1; mem_req low.
  - Ack and timeout in the same cycle: ack wins, err=0.
- FIN: exactly one cycle; done=1, err per flag. Then IDLE; counter cleared.
  - mem_be and mem_wdata clear to 0 on leaving REQ.
- start while busy (REQ/FIN) is ignored, not queued. start in the cycle after FIN (IDLE) is accepted.
- Latency:
  - start at cycle 0 → mem_req at cycle 1.
  - ack sampled at cycle k → done at cycle k+1.
  - Zero-wait memory (ack at cycle 1) → done at cycle 2.
  - Misaligned start at cycle 0 → done+err at cycle 1.
- Inputs size, addr and wdata are sampled only on the accepting start cycle; later changes have no effect.

Test Plan:
- Reset mid-REQ: start sw addr=0x100, deassert rst_n while mem_req=1 → all outputs 0 immediately; after release, IDLE with busy=0.
- sb addr=0x1003, wdata=0x123456AB, ack at first REQ cycle → mem_addr=0x1000, mem_wdata=0xABABABAB, mem_be=1000; done=1 err=0 two cycles after start.
- sh addr=0x2002, wdata=0xDEADBEEF, ack after 3 wait cycles → mem_be=1100, mem_wdata=0xBEEFBEEF, held stable 4 cycles; done one cycle after ack.
- sw addr=0x3002 → no mem_req; done=1 err=1 at cycle 1. Repeat with sh addr=0x3001 and size=11 → same response.
- sw addr=0x4000, TIMEOUT=16, no ack → mem_req high 16 cycles, then done=1 err=1; a start pulsed during REQ is ignored (no second request).
- Back-to-back: second start in the first IDLE cycle after done → accepted; mem_req reasserts the next cycle with the new lanes and enables.
